// File: rtl/jtgng_sdram_ctrl_if.sv
// Scheduler-side bus of the SDRAM command sequencer.
// Carries read slot strobes, download writes and returned data.
interface jtgng_sdram_ctrl_if;
   logic        rd_req;
   logic [21:0] addr;
   logic        autorefresh;
   logic        downloading;
   logic        prog_we;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask;
   logic        prog_ack;
   logic [15:0] data_read;
   logic        data_rdy;
   logic        init_done;
   logic        overrun;

   modport master (
      output rd_req, addr, autorefresh, downloading,
      output prog_we, prog_addr, prog_data, prog_mask,
      input  prog_ack, data_read, data_rdy, init_done, overrun
   );

   modport slave (
      input  rd_req, addr, autorefresh, downloading,
      input  prog_we, prog_addr, prog_data, prog_mask,
      output prog_ack, data_read, data_rdy, init_done, overrun
   );
endinterface

// File: rtl/jtgng_sdram_ctrl.sv
// Single-bank SDRAM sequencer: power-up init, ACT/READ/WRITE
// with auto-precharge, refresh, and one pending slot per request kind.
module jtgng_sdram_ctrl #(
   parameter int INIT_WAIT = 9600,
   parameter int CL        = 2,
   parameter int TRCD      = 2,
   parameter int TRP       = 2,
   parameter int TRC       = 7,
   parameter int TRFC      = 8
) (
   input  logic        clk,
   input  logic        rst,
   jtgng_sdram_ctrl_if.slave bus,
   output logic        sdram_cke,
   output logic [3:0]  sdram_cmd,
   output logic [12:0] sdram_a,
   output logic [1:0]  sdram_ba,
   output logic [1:0]  sdram_dqm,
   input  logic [15:0] dq_in,
   output logic [15:0] dq_out,
   output logic        dq_oe
);
   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_MRS = 4'b0000;
   localparam logic [12:0] MRS_A =
      {3'b000, 1'b1, 2'b00, 3'(CL), 1'b0, 3'b000};

   typedef enum logic [2:0] {
      S_INIT_WAIT, S_INIT_PRE, S_INIT_REF, S_INIT_MRS,
      S_WAIT, S_IDLE, S_RW
   } st_t;

   st_t         st, st_n, ret, ret_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  refcnt, refcnt_n;
   logic        op_wr, op_wr_n;
   logic [8:0]  col, col_n;
   logic [15:0] wd, wd_n;
   logic [1:0]  wm, wm_n;
   logic [3:0]  cmd_n;
   logic [12:0] a_n;
   logic [1:0]  dqm_n;
   logic        oe_n, ack_n, rd_start;
   logic [15:0] dqo_n;
   logic        take_rd, take_wr, take_ref;
   logic [CL:0] rd_sh;
   logic        init_done, dl_q;

   logic        rd_pend, wr_pend, ref_pend;
   logic [21:0] rd_addr, wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_mask;
   logic        rd_acc, wr_acc, ref_acc, dl_rise;
   logic        rd_have, wr_have, ref_have;
   logic [21:0] rd_a, wr_a;

   assign rd_acc   = bus.rd_req & init_done & ~bus.downloading;
   assign wr_acc   = bus.prog_we & init_done & bus.downloading;
   assign ref_acc  = bus.rd_req & bus.autorefresh & init_done;
   assign dl_rise  = bus.downloading & ~dl_q;
   assign rd_have  = rd_acc | (rd_pend & ~bus.downloading);
   assign wr_have  = wr_acc | wr_pend;
   assign ref_have = ref_acc | ref_pend;
   assign rd_a     = rd_acc ? bus.addr : rd_addr;
   assign wr_a     = wr_acc ? bus.prog_addr : wr_addr;
   assign sdram_ba = 2'b00;
   assign bus.init_done = init_done;

   always_comb begin
      st_n     = st;
      ret_n    = ret;
      cnt_n    = cnt;
      refcnt_n = refcnt;
      op_wr_n  = op_wr;
      col_n    = col;
      wd_n     = wd;
      wm_n     = wm;
      cmd_n    = C_NOP;
      a_n      = sdram_a;
      dqm_n    = 2'b11;
      oe_n     = 1'b0;
      dqo_n    = dq_out;
      ack_n    = 1'b0;
      rd_start = 1'b0;
      take_rd  = 1'b0;
      take_wr  = 1'b0;
      take_ref = 1'b0;
      unique case (st)
         S_INIT_WAIT: begin
            if (cnt == 16'(INIT_WAIT - 1)) begin
               st_n  = S_INIT_PRE;
               cnt_n = '0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         S_INIT_PRE: begin
            cmd_n    = C_PRE;
            a_n      = 13'h0400;
            cnt_n    = 16'(TRP - 2);
            refcnt_n = '0;
            ret_n    = S_INIT_REF;
            st_n     = S_WAIT;
         end
         S_INIT_REF: begin
            cmd_n    = C_REF;
            refcnt_n = refcnt + 3'd1;
            cnt_n    = 16'(TRFC - 1);
            ret_n    = (refcnt == 3'd7) ? S_INIT_MRS : S_INIT_REF;
            st_n     = S_WAIT;
         end
         S_INIT_MRS: begin
            cmd_n = C_MRS;
            a_n   = MRS_A;
            cnt_n = '0;
            ret_n = S_IDLE;
            st_n  = S_WAIT;
         end
         S_WAIT: begin
            if (cnt == '0) st_n = ret;
            else           cnt_n = cnt - 16'd1;
         end
         S_IDLE: begin
            if (rd_have) begin
               take_rd = 1'b1;
               op_wr_n = 1'b0;
               col_n   = rd_a[8:0];
               cmd_n   = C_ACT;
               a_n     = rd_a[21:9];
               cnt_n   = 16'(TRCD - 2);
               ret_n   = S_RW;
               st_n    = S_WAIT;
            end else if (wr_have) begin
               take_wr = 1'b1;
               op_wr_n = 1'b1;
               col_n   = wr_a[8:0];
               wd_n    = wr_acc ? bus.prog_data : wr_data;
               wm_n    = wr_acc ? bus.prog_mask : wr_mask;
               cmd_n   = C_ACT;
               a_n     = wr_a[21:9];
               cnt_n   = 16'(TRCD - 2);
               ret_n   = S_RW;
               st_n    = S_WAIT;
            end else if (ref_have) begin
               take_ref = 1'b1;
               cmd_n    = C_REF;
               cnt_n    = 16'(TRFC - 1);
               ret_n    = S_IDLE;
               st_n     = S_WAIT;
            end
         end
         S_RW: begin
            cmd_n    = op_wr ? C_WR : C_RD;
            a_n      = {2'b00, 1'b1, 1'b0, col};
            dqm_n    = op_wr ? wm : 2'b00;
            oe_n     = op_wr;
            dqo_n    = op_wr ? wd : dq_out;
            ack_n    = op_wr;
            rd_start = ~op_wr;
            // hold off the next ACT until TRC after this one
            cnt_n    = 16'(TRC - TRCD - 2);
            ret_n    = S_IDLE;
            st_n     = S_WAIT;
         end
         default: st_n = S_INIT_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st            <= S_INIT_WAIT;
         ret           <= S_INIT_WAIT;
         cnt           <= '0;
         refcnt        <= '0;
         op_wr         <= 1'b0;
         col           <= '0;
         wd            <= '0;
         wm            <= 2'b11;
         sdram_cke     <= 1'b0;
         sdram_cmd     <= C_NOP;
         sdram_a       <= '0;
         sdram_dqm     <= 2'b11;
         dq_oe         <= 1'b0;
         dq_out        <= '0;
         bus.prog_ack  <= 1'b0;
         rd_sh         <= '0;
         bus.data_read <= '0;
         bus.data_rdy  <= 1'b0;
         init_done     <= 1'b0;
      end else begin
         st            <= st_n;
         ret           <= ret_n;
         cnt           <= cnt_n;
         refcnt        <= refcnt_n;
         op_wr         <= op_wr_n;
         col           <= col_n;
         wd            <= wd_n;
         wm            <= wm_n;
         sdram_cke     <= 1'b1;
         sdram_cmd     <= cmd_n;
         sdram_a       <= a_n;
         sdram_dqm     <= dqm_n;
         dq_oe         <= oe_n;
         dq_out        <= dqo_n;
         bus.prog_ack  <= ack_n;
         // rd_sh[CL] marks the cycle the read word is on DQ
         rd_sh         <= {rd_sh[CL-1:0], rd_start};
         bus.data_rdy  <= rd_sh[CL];
         if (rd_sh[CL]) bus.data_read <= dq_in;
         if (st_n == S_IDLE) init_done <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend     <= 1'b0;
         wr_pend     <= 1'b0;
         ref_pend    <= 1'b0;
         rd_addr     <= '0;
         wr_addr     <= '0;
         wr_data     <= '0;
         wr_mask     <= 2'b11;
         dl_q        <= 1'b0;
         bus.overrun <= 1'b0;
      end else begin
         dl_q <= bus.downloading;
         if (take_rd) begin
            rd_pend <= 1'b0;
         end else if (rd_acc) begin
            rd_pend <= 1'b1;
            rd_addr <= bus.addr;
         end
         if (dl_rise) rd_pend <= 1'b0;
         if (take_wr) begin
            wr_pend <= 1'b0;
         end else if (wr_acc) begin
            wr_pend <= 1'b1;
            wr_addr <= bus.prog_addr;
            wr_data <= bus.prog_data;
            wr_mask <= bus.prog_mask;
         end
         if (take_ref)     ref_pend <= 1'b0;
         else if (ref_acc) ref_pend <= 1'b1;
         if ((rd_acc & rd_pend) | (wr_acc & wr_pend) |
             (ref_acc & ref_pend))
            bus.overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_jtgng_sdram_ctrl.sv
// Bench for jtgng_sdram_ctrl: SDRAM read model on DQ, command log,
// and a scoreboard of expected read words.
module tb_jtgng_sdram_ctrl;
   localparam int CL   = 2;
   localparam int TRCD = 2;
   localparam int TRP  = 2;
   localparam int TRC  = 7;
   localparam int TRFC = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sdram_cke, dq_oe;
   logic [3:0]  sdram_cmd;
   logic [12:0] sdram_a;
   logic [1:0]  sdram_ba, sdram_dqm;
   logic [15:0] dq_in, dq_out;

   always #5 clk = ~clk;

   jtgng_sdram_ctrl_if bus();

   jtgng_sdram_ctrl #(.INIT_WAIT(16), .CL(CL), .TRCD(TRCD),
      .TRP(TRP), .TRC(TRC), .TRFC(TRFC)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd),
      .sdram_a(sdram_a), .sdram_ba(sdram_ba),
      .sdram_dqm(sdram_dqm), .dq_in(dq_in),
      .dq_out(dq_out), .dq_oe(dq_oe)
   );

   typedef struct { logic [15:0] d; int c; } exp_t;
   typedef struct { int c; logic [15:0] d; } drv_t;
   typedef struct {
      int c; logic [3:0] cmd; logic [12:0] a;
      logic [1:0] dqm; logic oe; logic [15:0] dq;
   } ev_t;

   exp_t exp_q[$];
   drv_t drv_q[$];
   ev_t  log_q[$];
   exp_t e_pop;
   int cyc = 0;
   int n_chk = 0, n_fail = 0;
   int ack_cnt = 0, oe_cnt = 0, rdy_cnt = 0;
   logic [12:0] row_open = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(logic [21:0] ad);
      return (ad == 22'h12345) ? 16'hBEEF : (ad[15:0] ^ 16'h5A5A);
   endfunction

   initial begin
      dq_in = 16'hDEAD;
      forever begin
         @(negedge clk);
         dq_in = 16'hDEAD;
         if (drv_q.size() > 0 && drv_q[0].c == cyc) begin
            dq_in = drv_q[0].d;
            void'(drv_q.pop_front());
         end
         if (!rst) begin
            if (sdram_cmd != 4'b0111)
               log_q.push_back('{c: cyc, cmd: sdram_cmd, a: sdram_a,
                  dqm: sdram_dqm, oe: dq_oe, dq: dq_out});
            if (sdram_cmd == 4'b0011) row_open = sdram_a;
            if (sdram_cmd == 4'b0101)
               drv_q.push_back('{c: cyc + CL,
                  d: mem_word({row_open, sdram_a[8:0]})});
            if (dq_oe) oe_cnt++;
            if (bus.prog_ack) begin
               ack_cnt++;
               chk("ack_on_wr", 32'(sdram_cmd), 32'h4);
            end
            if (bus.data_rdy) begin
               rdy_cnt++;
               if (exp_q.size() == 0) begin
                  chk("spurious_rdy", 1, 0);
               end else begin
                  e_pop = exp_q.pop_front();
                  chk("rd_data", 32'(bus.data_read), 32'(e_pop.d));
                  if (e_pop.c >= 0) chk("rd_lat", cyc, e_pop.c);
               end
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // push: 0 = no result expected, 1 = timed, 2 = untimed
   task automatic pulse_rd(input logic [21:0] ad, input logic ar,
                           input int push, output int t);
      t = cyc;
      bus.addr = ad;
      bus.autorefresh = ar;
      bus.rd_req = 1'b1;
      if (push == 1)
         exp_q.push_back('{d: mem_word(ad), c: t + 2 + TRCD + CL});
      else if (push == 2)
         exp_q.push_back('{d: mem_word(ad), c: -1});
      @(negedge clk);
      bus.rd_req = 1'b0;
      bus.autorefresh = 1'b0;
   endtask

   task automatic pulse_we(input logic [21:0] ad, input logic [15:0] d,
                           input logic [1:0] m, output int t);
      t = cyc;
      bus.prog_addr = ad;
      bus.prog_data = d;
      bus.prog_mask = m;
      bus.prog_we = 1'b1;
      @(negedge clk);
      bus.prog_we = 1'b0;
   endtask

   task automatic wait_init();
      for (int i = 0; i < 3000 && !bus.init_done; i++) @(negedge clk);
      chk("init_done", 32'(bus.init_done), 1);
   endtask

   task automatic check_init();
      chk("init_len", log_q.size(), 10);
      if (log_q.size() == 10) begin
         chk("init_pre", {log_q[0].cmd, 3'b0, log_q[0].a}, {4'h2, 16'h0400});
         for (int i = 1; i <= 8; i++) begin
            chk("init_ref", 32'(log_q[i].cmd), 32'h1);
            chk("init_gap", 32'(log_q[i].c - log_q[i-1].c >=
               ((i == 1) ? TRP : TRFC)), 1);
         end
         chk("init_mrs", {log_q[9].cmd, 3'b0, log_q[9].a}, {4'h0, 16'h0220});
      end
   endtask

   int t, t2, r0, a0, o0;

   initial begin
      bus.rd_req = 0; bus.addr = '0; bus.autorefresh = 0;
      bus.downloading = 0; bus.prog_we = 0; bus.prog_addr = '0;
      bus.prog_data = '0; bus.prog_mask = '0;
      @(negedge clk); #1;
      chk("rst_cmd", 32'(sdram_cmd), 32'h7);
      chk("rst_cke", 32'(sdram_cke), 0);
      chk("rst_a", 32'(sdram_a), 0);
      chk("rst_dqm_oe", {sdram_dqm, dq_oe}, 3'b110);
      chk("rst_outs", {bus.data_read, bus.data_rdy, bus.prog_ack,
         bus.init_done, bus.overrun}, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("cke_on", 32'(sdram_cke), 1);
      cycles(2);
      pulse_rd(22'h00100, 1'b0, 0, t);
      wait_init();
      check_init();
      log_q.delete();
      chk("ovr_after_init", 32'(bus.overrun), 0);
      cycles(3);

      pulse_rd(22'h12345, 1'b0, 1, t);
      cycles(20);
      chk("rd_len", log_q.size(), 2);
      if (log_q.size() >= 2) begin
         chk("rd_act", {log_q[0].cmd, 3'b0, log_q[0].a}, {4'h3, 16'h0091});
         chk("rd_act_t", log_q[0].c, t + 1);
         chk("rd_rd", {log_q[1].cmd, 3'b0, log_q[1].a}, {4'h5, 16'h0545});
         chk("rd_rd_t", log_q[1].c, t + 1 + TRCD);
         chk("rd_dqm", 32'(log_q[1].dqm), 0);
      end
      chk("rd_rdy_cnt", rdy_cnt, 1);
      log_q.delete();

      pulse_rd(22'h00ABC, 1'b1, 1, t);
      cycles(8);
      pulse_rd(22'h00DEF, 1'b0, 2, t2);
      cycles(30);
      chk("ar_len", log_q.size(), 5);
      if (log_q.size() >= 5) begin
         chk("ar_seq", {log_q[0].cmd, log_q[1].cmd, log_q[2].cmd,
            log_q[3].cmd, log_q[4].cmd}, 20'h35135);
         chk("ar_trc", 32'(log_q[2].c >= t + 1 + TRC), 1);
         chk("ar_trfc", 32'(log_q[3].c - log_q[2].c >= TRFC + 1), 1);
      end
      log_q.delete();

      bus.downloading = 1;
      cycles(2);
      pulse_rd(22'h00555, 1'b0, 0, t);
      cycles(10);
      chk("dl_rd_ignored", log_q.size(), 0);
      a0 = ack_cnt; o0 = oe_cnt;
      pulse_we(22'h000200, 16'hA55A, 2'b01, t);
      cycles(15);
      chk("wr_len", log_q.size(), 2);
      if (log_q.size() >= 2) begin
         chk("wr_act", {log_q[0].cmd, 3'b0, log_q[0].a}, {4'h3, 16'h0001});
         chk("wr_act_t", log_q[0].c, t + 1);
         chk("wr_wr", {log_q[1].cmd, 3'b0, log_q[1].a}, {4'h4, 16'h0400});
         chk("wr_wr_t", log_q[1].c, t + 1 + TRCD);
         chk("wr_bus", {log_q[1].dqm, log_q[1].oe, log_q[1].dq},
            {2'b01, 1'b1, 16'hA55A});
      end
      chk("wr_ack_cnt", ack_cnt - a0, 1);
      chk("wr_oe_cnt", oe_cnt - o0, 1);
      bus.downloading = 0;
      cycles(3);
      log_q.delete();
      pulse_we(22'h000300, 16'h1234, 2'b00, t);
      cycles(10);
      chk("we_ignored", log_q.size(), 0);

      chk("ovr_pre", 32'(bus.overrun), 0);
      r0 = rdy_cnt;
      pulse_rd(22'h01111, 1'b0, 1, t);
      cycles(1);
      pulse_rd(22'h02222, 1'b0, 0, t2);
      cycles(1);
      pulse_rd(22'h03333, 1'b0, 2, t2);
      cycles(40);
      chk("ovr_set", 32'(bus.overrun), 1);
      chk("ovr_rdy_cnt", rdy_cnt - r0, 2);

      r0 = rdy_cnt;
      pulse_rd(22'h04444, 1'b0, 0, t);
      cycles(3);
      rst = 1;
      #1;
      chk("mid_rst_cmd", 32'(sdram_cmd), 32'h7);
      chk("mid_rst_outs", {sdram_cke, dq_oe, sdram_dqm, bus.init_done,
         bus.overrun, bus.data_rdy}, 7'b0011000);
      cycles(3);
      rst = 0;
      log_q.delete();
      wait_init();
      check_init();
      cycles(5);
      chk("no_rdy_after_rst", rdy_cnt, r0);
      chk("exp_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
         n_chk, n_fail);
      $finish;
   end
endmodule
